// File: rtl/cfg_sequencer.sv
// cfg_sequencer: walks a configuration ROM and sends each 24-bit entry to an
// I2C byte master as one 3-byte transaction, MSB first. After the preamble
// entries it waits a fixed pause (device power-up settle time) before sending
// the remaining entries.
// Optional build macro CFG_SEQ_NACK_ABORT_EN: a slave NACK aborts the sequence
// into a sticky ERROR state. Without it, NACKs are ignored and err_o is 0.
module cfg_sequencer #(
  parameter int MEM_DEPTH    = 326,
  parameter int MEM_WIDTH    = 24,
  parameter int DATA_WIDTH   = 8,
  parameter int PREAMBLE_LEN = 3,
  parameter int PAUSE_CYCLES = 37_500_000
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [$clog2(MEM_DEPTH)-1:0] rom_addr_o,
  input  logic [MEM_WIDTH-1:0]         rom_data_i,
  output logic [DATA_WIDTH-1:0]        tx_data_o,
  output logic                         tx_valid_o,
  input  logic                         tx_ready_i,
  output logic                         tx_first_o,
  output logic                         tx_last_o,
  input  logic                         txn_done_i,
  input  logic                         nack_i
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int NBYTES = MEM_WIDTH / DATA_WIDTH;
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = $clog2(PAUSE_CYCLES + 1);

  localparam logic [ADDR_W-1:0] PRE_LAST_IDX = ADDR_W'(PREAMBLE_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE    = BCNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0]  PAUSE_LAST   = CNT_W'(PAUSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LOAD      = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_PAUSE     = 3'd5,
`ifdef CFG_SEQ_NACK_ABORT_EN
    S_FINISH    = 3'd6,
    S_ERROR     = 3'd7
`else
    S_FINISH    = 3'd6
`endif
  } state_t;

  state_t               state_reg, state_next;
  logic [ADDR_W-1:0]    index_reg;
  logic [CNT_W-1:0]     pause_cnt_reg;
  logic [MEM_WIDTH-1:0] shift_reg;
  logic [BCNT_W-1:0]    byte_cnt_reg;
  logic                 handshake;
  logic                 nack_abort;

  assign handshake = tx_valid_o && tx_ready_i;

`ifdef CFG_SEQ_NACK_ABORT_EN
  assign nack_abort = nack_i;
`else
  // NACKs are deliberately ignored in this build.
  logic unused_nack;
  assign unused_nack = nack_i;
  assign nack_abort  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; a NACK beats txn_done_i when both arrive together.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_i) state_next = S_FETCH;
      S_FETCH: state_next = S_LOAD;
      S_LOAD:  state_next = S_SEND;
      S_SEND: begin
`ifdef CFG_SEQ_NACK_ABORT_EN
        if (nack_abort) state_next = S_ERROR;
        else
`endif
        if (handshake && byte_cnt_reg == LAST_BYTE) state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
`ifdef CFG_SEQ_NACK_ABORT_EN
        if (nack_abort) state_next = S_ERROR;
        else
`endif
        if (txn_done_i) begin
          if (index_reg == PRE_LAST_IDX) state_next = S_PAUSE;
          else if (index_reg == LAST_IDX) state_next = S_FINISH;
          else                            state_next = S_FETCH;
        end
      end
      S_PAUSE: begin
        if (pause_cnt_reg == PAUSE_LAST)
          state_next = (index_reg == LAST_IDX) ? S_FINISH : S_FETCH;
      end
      S_FINISH: state_next = S_IDLE;
`ifdef CFG_SEQ_NACK_ABORT_EN
      S_ERROR: if (start_i) state_next = S_FETCH;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: entry index, pause counter, byte shifter and sticky error.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      index_reg     <= '0;
      pause_cnt_reg <= '0;
      shift_reg     <= '0;
      byte_cnt_reg  <= '0;
    end else begin
      // Entering FETCH from an idle/error state restarts at entry 0;
      // from WAIT_DONE or PAUSE it moves on to the next entry.
      if (state_next == S_FETCH) begin
        if (state_reg == S_WAIT_DONE || state_reg == S_PAUSE)
          index_reg <= index_reg + 1'b1;
        else
          index_reg <= '0;
      end

      if (state_reg == S_PAUSE && pause_cnt_reg != PAUSE_LAST)
        pause_cnt_reg <= pause_cnt_reg + 1'b1;
      else
        pause_cnt_reg <= '0;

      if (state_reg == S_LOAD) begin
        shift_reg    <= rom_data_i;
        byte_cnt_reg <= '0;
      end else if (state_reg == S_SEND && handshake && !nack_abort) begin
        shift_reg    <= {shift_reg[MEM_WIDTH-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
      end
    end
  end

`ifdef CFG_SEQ_NACK_ABORT_EN
  logic err_reg;

  // Sticky abort flag: set on the way into ERROR, cleared by a restart.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)                                      err_reg <= 1'b0;
    else if (state_next == S_ERROR)                  err_reg <= 1'b1;
    else if (state_reg == S_ERROR && start_i)        err_reg <= 1'b0;
  end

  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

  assign rom_addr_o = index_reg;

  // Outputs decoded from state so reset drops tx_valid_o at once.
  always_comb begin
    busy_o     = 1'b1;
    done_o     = 1'b0;
    tx_valid_o = 1'b0;
    tx_first_o = 1'b0;
    tx_last_o  = 1'b0;
    tx_data_o  = '0;
    case (state_reg)
      S_IDLE:   busy_o = 1'b0;
`ifdef CFG_SEQ_NACK_ABORT_EN
      S_ERROR:  busy_o = 1'b0;
`endif
      S_FINISH: done_o = 1'b1;
      S_SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = shift_reg[MEM_WIDTH-1 -: DATA_WIDTH];
        tx_first_o = (byte_cnt_reg == '0);
        tx_last_o  = (byte_cnt_reg == LAST_BYTE);
      end
      default: ;
    endcase
  end

endmodule
